// File: rtl/seg_scan_display.sv
// Four-digit hex scanner for a common-anode 7-segment display: shadows a 16-bit value
// and overflow flag on load, then refreshes one digit per prescaler tick.
module seg_scan_display #(
  parameter int DIV_W    = 17,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        ovf,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  logic [DIV_W-1:0] presc_reg;
  logic [1:0]       idx_reg;
  logic [15:0]      shadow_reg;
  logic             shadow_ovf_reg;
  logic [6:0]       seg_reg;
  logic [3:0]       an_reg;
  logic             dp_reg;

  logic             tick;
  logic [3:0]       nib;
  logic [3:0]       lz;
  logic             blank;
  logic [6:0]       dec;
  logic [6:0]       seg_next;
  logic [3:0]       an_next;
  logic             dp_next;

  assign tick = &presc_reg;

  // lz[k]: digit k is a leading zero (nibbles k..3 all zero); digit 0 always shows
  assign lz[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      assign lz[gi] = BLANK_LZ && (shadow_reg[15:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    nib = 4'h0;
    case (idx_reg)
      2'd0:    nib = shadow_reg[3:0];
      2'd1:    nib = shadow_reg[7:4];
      2'd2:    nib = shadow_reg[11:8];
      default: nib = shadow_reg[15:12];
    endcase
  end

  // Active-low {g,f,e,d,c,b,a}
  always_comb begin
    dec = 7'h7F;
    case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
  end

  always_comb begin
    blank    = lz[idx_reg];
    seg_next = blank ? 7'h7F : dec;
    an_next  = blank ? 4'hF : ~(4'b0001 << idx_reg);
    dp_next  = !((idx_reg == 2'd0) && shadow_ovf_reg);
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      presc_reg      <= '0;
      idx_reg        <= 2'd0;
      shadow_reg     <= 16'h0000;
      shadow_ovf_reg <= 1'b0;
      seg_reg        <= 7'h7F;
      an_reg         <= 4'hF;
      dp_reg         <= 1'b1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
      // A load coinciding with tick lands after this update, so the old shadow is shown
      if (load) begin
        shadow_reg     <= value;
        shadow_ovf_reg <= ovf;
      end
      if (tick) begin
        idx_reg <= idx_reg + 2'd1;
        seg_reg <= seg_next;
        an_reg  <= an_next;
        dp_reg  <= dp_next;
      end
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: one blanking and one non-blanking instance
// share stimulus; each row is one digit step (4 clocks at DIV_W=2).
module tb_seg_scan_display;

  logic        clkin = 1'b0;
  logic        rst   = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        ovf   = 1'b0;
  logic [6:0]  seg_b, seg_n;
  logic [3:0]  an_b, an_n;
  logic        dp_b, dp_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clkin = ~clkin;

  seg_scan_display #(.DIV_W(2), .BLANK_LZ(1'b1)) dut_b (
    .clkin(clkin), .rst(rst), .load(load), .value(value), .ovf(ovf),
    .seg(seg_b), .an(an_b), .dp(dp_b)
  );

  seg_scan_display #(.DIV_W(2), .BLANK_LZ(1'b0)) dut_n (
    .clkin(clkin), .rst(rst), .load(load), .value(value), .ovf(ovf),
    .seg(seg_n), .an(an_n), .dp(dp_n)
  );

  typedef struct {
    logic        ld;
    logic        co;
    logic [15:0] val;
    logic        ov;
    logic [6:0]  seg_b;
    logic [3:0]  an_b;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        dp;
  } vec_t;

  localparam int NV = 36;
  vec_t vt [NV];

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int row, input logic [6:0] sb, input logic [3:0] ab,
                         input logic [6:0] sn, input logic [3:0] anx, input logic d);
    chk({nm, "_seg_b"}, row, {9'd0, seg_b}, {9'd0, sb});
    chk({nm, "_an_b"},  row, {12'd0, an_b}, {12'd0, ab});
    chk({nm, "_dp_b"},  row, {15'd0, dp_b}, {15'd0, d});
    chk({nm, "_seg_n"}, row, {9'd0, seg_n}, {9'd0, sn});
    chk({nm, "_an_n"},  row, {12'd0, an_n}, {12'd0, anx});
    chk({nm, "_dp_n"},  row, {15'd0, dp_n}, {15'd0, d});
  endtask

  task automatic edge1();
    @(posedge clkin);
    #1;
  endtask

  // One digit step; co=1 places the load on the tick edge itself
  task automatic step(input logic ld, input logic co, input logic [15:0] v, input logic o);
    value = v;
    ovf   = o;
    if (co) begin
      repeat (3) edge1();
      load = ld;
      edge1();
      load = 1'b0;
    end else begin
      load = ld;
      edge1();
      load = 1'b0;
      repeat (3) edge1();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // digit 1..3 visits: 0507 -> 0280 -> 0000 -> 0050 -> 0507 -> ABCD (coincident load)
    vt[0]  = '{1'b1, 1'b0, 16'h0507, 1'b0, 7'h40, 4'hD, 7'h40, 4'hD, 1'b1};
    vt[1]  = '{1'b0, 1'b0, 16'h0507, 1'b0, 7'h12, 4'hB, 7'h12, 4'hB, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 16'h0507, 1'b0, 7'h7F, 4'hF, 7'h40, 4'h7, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 16'h0507, 1'b0, 7'h78, 4'hE, 7'h78, 4'hE, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 16'h0280, 1'b1, 7'h00, 4'hD, 7'h00, 4'hD, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 16'h0280, 1'b1, 7'h24, 4'hB, 7'h24, 4'hB, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 16'h0280, 1'b1, 7'h7F, 4'hF, 7'h40, 4'h7, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 16'h0280, 1'b1, 7'h40, 4'hE, 7'h40, 4'hE, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 7'h7F, 4'hF, 7'h40, 4'hD, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'h7F, 4'hF, 7'h40, 4'hB, 1'b1};
    vt[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'h7F, 4'hF, 7'h40, 4'h7, 1'b1};
    vt[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'h40, 4'hE, 7'h40, 4'hE, 1'b1};
    vt[12] = '{1'b1, 1'b0, 16'h0050, 1'b0, 7'h12, 4'hD, 7'h12, 4'hD, 1'b1};
    vt[13] = '{1'b0, 1'b0, 16'h0050, 1'b0, 7'h7F, 4'hF, 7'h40, 4'hB, 1'b1};
    vt[14] = '{1'b0, 1'b0, 16'h0050, 1'b0, 7'h7F, 4'hF, 7'h40, 4'h7, 1'b1};
    vt[15] = '{1'b0, 1'b0, 16'h0050, 1'b0, 7'h40, 4'hE, 7'h40, 4'hE, 1'b1};
    vt[16] = '{1'b1, 1'b0, 16'h0507, 1'b0, 7'h40, 4'hD, 7'h40, 4'hD, 1'b1};
    vt[17] = '{1'b0, 1'b0, 16'h0507, 1'b0, 7'h12, 4'hB, 7'h12, 4'hB, 1'b1};
    vt[18] = '{1'b0, 1'b0, 16'h0507, 1'b0, 7'h7F, 4'hF, 7'h40, 4'h7, 1'b1};
    vt[19] = '{1'b1, 1'b1, 16'hABCD, 1'b1, 7'h78, 4'hE, 7'h78, 4'hE, 1'b1};
    vt[20] = '{1'b0, 1'b0, 16'hABCD, 1'b1, 7'h46, 4'hD, 7'h46, 4'hD, 1'b1};
    vt[21] = '{1'b0, 1'b0, 16'hABCD, 1'b1, 7'h03, 4'hB, 7'h03, 4'hB, 1'b1};
    vt[22] = '{1'b0, 1'b0, 16'hABCD, 1'b1, 7'h08, 4'h7, 7'h08, 4'h7, 1'b1};
    vt[23] = '{1'b0, 1'b0, 16'hABCD, 1'b1, 7'h21, 4'hE, 7'h21, 4'hE, 1'b0};
    // three scans with value/ovf wandering but no load: display must hold ABCD
    for (int i = 24; i < NV; i++) begin
      vec_t r;
      r.ld = 1'b0; r.co = 1'b0;
      r.val = 16'(i * 16'h0F3B);
      r.ov  = i[0];
      case ((i - 24) % 4)
        0:       begin r.seg_b = 7'h46; r.an_b = 4'hD; r.dp = 1'b1; end
        1:       begin r.seg_b = 7'h03; r.an_b = 4'hB; r.dp = 1'b1; end
        2:       begin r.seg_b = 7'h08; r.an_b = 4'h7; r.dp = 1'b1; end
        default: begin r.seg_b = 7'h21; r.an_b = 4'hE; r.dp = 1'b0; end
      endcase
      r.seg_n = r.seg_b;
      r.an_n  = r.an_b;
      vt[i] = r;
    end

    // power-up reset
    #1 rst = 1'b1;
    #1 chk_all("por", -1, 7'h7F, 4'hF, 7'h7F, 4'hF, 1'b1);
    @(posedge clkin);
    #1 rst = 1'b0;
    repeat (3) edge1();
    chk_all("first_hold", -1, 7'h7F, 4'hF, 7'h7F, 4'hF, 1'b1);
    edge1();
    chk_all("first_tick", -1, 7'h40, 4'hE, 7'h40, 4'hE, 1'b1);

    // shadow 1234 with ovf, then reset mid-scan between clock edges
    step(1'b1, 1'b0, 16'h1234, 1'b1);
    chk_all("s1234_d1", -1, 7'h30, 4'hD, 7'h30, 4'hD, 1'b1);
    step(1'b0, 1'b0, 16'h1234, 1'b1);
    chk_all("s1234_d2", -1, 7'h24, 4'hB, 7'h24, 4'hB, 1'b1);
    @(posedge clkin);
    #3 rst = 1'b1;
    #1 chk_all("async_rst", -1, 7'h7F, 4'hF, 7'h7F, 4'hF, 1'b1);
    @(posedge clkin);
    #1 rst = 1'b0;
    chk_all("rst_held", -1, 7'h7F, 4'hF, 7'h7F, 4'hF, 1'b1);
    repeat (3) edge1();
    chk_all("rel_hold", -1, 7'h7F, 4'hF, 7'h7F, 4'hF, 1'b1);
    edge1();
    chk_all("rel_tick", -1, 7'h40, 4'hE, 7'h40, 4'hE, 1'b1);

    for (int i = 0; i < NV; i++) begin
      step(vt[i].ld, vt[i].co, vt[i].val, vt[i].ov);
      $display("vec %0d: load=%b val=%h an_b=%h seg_b=%h an_n=%h seg_n=%h dp=%b",
               i, vt[i].ld, vt[i].val, an_b, seg_b, an_n, seg_n, dp_b);
      chk_all("vec", i, vt[i].seg_b, vt[i].an_b, vt[i].seg_n, vt[i].an_n, vt[i].dp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
